// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, variable-latency imem requests, 2-entry queue.
// Define FETCH_BYPASS_EN to forward responses straight to the decoder when empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    logic [31:0] fetch_pc;
    logic [1:0]  live;
    logic [1:0]  drop;
    logic [1:0]  count;
    logic [31:0] q_word [2];
    logic [31:0] q_pc   [2];
    logic        q_head;
    logic [31:0] pf     [2];
    logic        pf_head;

    logic        accept;
    logic        rsp_drop;
    logic        rsp_keep;
    logic        bypass;
    logic        pop;
    logic        pop_q;
    logic        push;
    logic        q_wr;
    logic        pf_wr;
    logic [2:0]  pend;
    logic [1:0]  drop_redir;

    assign imem_addr = fetch_pc;
    assign imem_req  = rst_n && !redirect
                    && (({1'b0, live} + {1'b0, drop}) < 3'd2)
                    && (({1'b0, live} + {1'b0, count}) < 3'd2);

    assign accept   = imem_req && imem_ready;
    assign rsp_drop = imem_rvalid && (drop != 2'd0);
    assign rsp_keep = imem_rvalid && (drop == 2'd0) && (live != 2'd0);

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_keep && (count == 2'd0) && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = !redirect && ((count != 2'd0) || bypass);
    assign instr       = bypass ? imem_rdata : q_word[q_head];
    assign instr_pc    = bypass ? pf[pf_head] : q_pc[q_head];

    assign pop   = instr_valid && instr_ready;
    assign pop_q = pop && !bypass;
    assign push  = rsp_keep && !(bypass && instr_ready);
    assign q_wr  = q_head ^ count[0];
    assign pf_wr = pf_head ^ live[0];

    // A response arriving with the redirect consumes one pending slot.
    always_comb begin
        pend = {1'b0, drop} + {1'b0, live};
        if (imem_rvalid && (pend != 3'd0))
            pend = pend - 3'd1;
        drop_redir = (pend > 3'd2) ? 2'd2 : pend[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            live      <= 2'd0;
            drop      <= 2'd0;
            count     <= 2'd0;
            q_head    <= 1'b0;
            pf_head   <= 1'b0;
            q_word[0] <= 32'd0;
            q_word[1] <= 32'd0;
            q_pc[0]   <= 32'd0;
            q_pc[1]   <= 32'd0;
            pf[0]     <= 32'd0;
            pf[1]     <= 32'd0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            live     <= 2'd0;
            count    <= 2'd0;
            drop     <= drop_redir;
        end else begin
            if (accept) begin
                fetch_pc  <= fetch_pc + 32'd4;
                pf[pf_wr] <= fetch_pc;
            end
            live <= live + {1'b0, accept} - {1'b0, rsp_keep};
            drop <= drop - {1'b0, rsp_drop};
            if (rsp_keep)
                pf_head <= ~pf_head;
            if (push) begin
                q_word[q_wr] <= imem_rdata;
                q_pc[q_wr]   <= pf[pf_head];
            end
            if (pop_q)
                q_head <= ~q_head;
            count <= count + {1'b0, push} - {1'b0, pop_q};
        end
    end

endmodule
